// File: rtl/socket_eeprom_cmd_parser.sv
// socket_eeprom_cmd_parser
//   Turns the UDP socket byte stream into 64-bit eeprom word reads/writes,
//   runs the eeprom req/done handshake and sends a reply frame back.
//   Commands (MSB first): 'W' addr d7..d0 (10 bytes), 'R' addr (2 bytes).
//   Replies: 'w' addr status, or 'r' addr status d7..d0.
// Ports
//   clk_125m, rst_n          clock, async active-low reset
//   net2pl_d/net2pl_wr       inbound socket bytes (no backpressure)
//   pl2net_d/pl2net_wr       outbound reply bytes, gated by pl2net_full
//   eeprom_idle              eeprom controller ready for a request
//   wr_req/wr_addr/wr_u64    write request (1 cycle), addr/data held after
//   wr_done                  write complete pulse
//   rd_req/rd_addr           read request (1 cycle), addr held after
//   rd_u64/rd_done           read data, valid in the rd_done cycle
//   busy                     command in progress (opcode accept .. last reply byte)
//   drop_cnt                 saturating count of discarded bytes
module socket_eeprom_cmd_parser #(
    parameter int PROT_ADDR = 240,
    parameter int FRAME_TO  = 12500000,
    parameter int EE_TO     = 125000000
) (
    input  logic        clk_125m,
    input  logic        rst_n,
    input  logic [7:0]  net2pl_d,
    input  logic        net2pl_wr,
    output logic [7:0]  pl2net_d,
    output logic        pl2net_wr,
    input  logic        pl2net_full,
    input  logic        eeprom_idle,
    output logic        wr_req,
    output logic [7:0]  wr_addr,
    output logic [63:0] wr_u64,
    input  logic        wr_done,
    output logic        rd_req,
    output logic [7:0]  rd_addr,
    input  logic [63:0] rd_u64,
    input  logic        rd_done,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    localparam int FTW = (FRAME_TO < 2) ? 1 : $clog2(FRAME_TO);
    localparam int ETW = (EE_TO < 2) ? 1 : $clog2(EE_TO);
    localparam logic [FTW-1:0] FRAME_LAST = FTW'(FRAME_TO - 1);
    localparam logic [ETW-1:0] EE_LAST    = ETW'(EE_TO - 1);
    localparam logic [8:0]     PROT_A     = 9'(PROT_ADDR);

    localparam logic [7:0] OP_W = 8'h57, OP_R = 8'h52;
    localparam logic [7:0] RP_W = 8'h77, RP_R = 8'h72;
    localparam logic [7:0] ST_OK = 8'h00, ST_ALIGN = 8'hE1, ST_PROT = 8'hE2, ST_TO = 8'hE3;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_CHECK, S_WAIT_IDLE, S_WAIT_DONE, S_REPLY
    } state_t;

    state_t         state, state_nxt;
    logic           is_wr;
    logic [7:0]     addr_q;
    logic [7:0]     status_q;
    logic [63:0]    rd_data_q;
    logic [3:0]     byte_cnt;   // bytes consumed of the current command
    logic [3:0]     idx;        // reply byte index
    logic [FTW-1:0] frame_tmr;
    logic [ETW-1:0] ee_tmr;

    logic           frame_exp, ee_exp, done_hit;
    logic [7:0]     chk_status;
    logic [3:0]     reply_last;
    logic [3:0]     drop_add;
    logic [63:0]    rd_shift;
    logic [16:0]    drop_sum;

    assign wr_addr = addr_q;
    assign rd_addr = addr_q;

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_nxt  = state;
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        pl2net_wr  = 1'b0;
        pl2net_d   = 8'h00;
        drop_add   = 4'd0;
        busy       = (state != S_IDLE);
        frame_exp  = (frame_tmr == FRAME_LAST) && !net2pl_wr;
        ee_exp     = (ee_tmr == EE_LAST);
        done_hit   = is_wr ? wr_done : rd_done;
        reply_last = is_wr ? 4'd2 : 4'd10;
        rd_shift   = rd_data_q >> {4'd10 - idx, 3'b000};

        chk_status = ST_OK;
        if (addr_q[2:0] != 3'd0)
            chk_status = ST_ALIGN;
        else if (is_wr && ({1'b0, addr_q} >= PROT_A))
            chk_status = ST_PROT;

        case (state)
            S_IDLE: begin
                if (net2pl_wr) begin
                    if (net2pl_d == OP_W || net2pl_d == OP_R)
                        state_nxt = S_ADDR;
                    else
                        drop_add = 4'd1;
                end
            end
            S_ADDR: begin
                if (net2pl_wr)
                    state_nxt = is_wr ? S_DATA : S_CHECK;
                else if (frame_exp) begin
                    state_nxt = S_IDLE;
                    drop_add  = byte_cnt;
                end
            end
            S_DATA: begin
                // opcode + addr + 7 data already consumed -> this is d0
                if (net2pl_wr && byte_cnt == 4'd9)
                    state_nxt = S_CHECK;
                else if (frame_exp) begin
                    state_nxt = S_IDLE;
                    drop_add  = byte_cnt;
                end
            end
            S_CHECK: begin
                state_nxt = (chk_status != ST_OK) ? S_REPLY : S_WAIT_IDLE;
                if (net2pl_wr) drop_add = 4'd1;
            end
            S_WAIT_IDLE: begin
                if (eeprom_idle) begin
                    wr_req    = is_wr;
                    rd_req    = !is_wr;
                    state_nxt = S_WAIT_DONE;
                end else if (ee_exp)
                    state_nxt = S_REPLY;
                if (net2pl_wr) drop_add = 4'd1;
            end
            S_WAIT_DONE: begin
                if (done_hit || ee_exp)
                    state_nxt = S_REPLY;
                if (net2pl_wr) drop_add = 4'd1;
            end
            S_REPLY: begin
                case (idx)
                    4'd0:    pl2net_d = is_wr ? RP_W : RP_R;
                    4'd1:    pl2net_d = addr_q;
                    4'd2:    pl2net_d = status_q;
                    default: pl2net_d = (status_q != ST_OK) ? 8'h00 : rd_shift[7:0];
                endcase
                if (!pl2net_full) begin
                    pl2net_wr = 1'b1;
                    if (idx == reply_last)
                        state_nxt = S_IDLE;
                end
                // a byte landing on the final reply cycle is still dropped
                if (net2pl_wr) drop_add = 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase

        drop_sum = {1'b0, drop_cnt} + 17'(drop_add);
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            is_wr     <= 1'b0;
            addr_q    <= 8'h00;
            wr_u64    <= 64'h0;
            rd_data_q <= 64'h0;
            status_q  <= 8'h00;
            byte_cnt  <= 4'd0;
            idx       <= 4'd0;
            frame_tmr <= '0;
            ee_tmr    <= '0;
            drop_cnt  <= 16'h0;
        end else begin
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            case (state)
                S_IDLE: begin
                    if (net2pl_wr && (net2pl_d == OP_W || net2pl_d == OP_R)) begin
                        is_wr     <= (net2pl_d == OP_W);
                        byte_cnt  <= 4'd1;
                        frame_tmr <= '0;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (net2pl_wr) begin
                        byte_cnt  <= byte_cnt + 4'd1;
                        frame_tmr <= '0;
                        if (state == S_ADDR) addr_q <= net2pl_d;
                        else                 wr_u64 <= {wr_u64[55:0], net2pl_d};
                    end else begin
                        frame_tmr <= frame_tmr + 1'b1;
                    end
                end
                S_CHECK: begin
                    status_q <= chk_status;
                    ee_tmr   <= '0;
                    idx      <= 4'd0;
                end
                S_WAIT_IDLE: begin
                    ee_tmr <= ee_tmr + 1'b1;
                    if (!eeprom_idle && ee_exp) status_q <= ST_TO;
                end
                S_WAIT_DONE: begin
                    ee_tmr <= ee_tmr + 1'b1;
                    if (done_hit) begin
                        status_q <= ST_OK;
                        if (!is_wr) rd_data_q <= rd_u64;
                    end else if (ee_exp)
                        status_q <= ST_TO;
                end
                S_REPLY: begin
                    if (!pl2net_full) idx <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
